// File: rtl/tdm_pkg.sv
// Shared types and sizing for the tdm_demux8 serial-to-parallel demultiplexer.
// TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME_SLOTS = LANES + 1;
`else
    localparam int FRAME_SLOTS = LANES;
`endif

    // Slot counter must also reach the parity slot when it exists.
    localparam int SLOT_W = $clog2(FRAME_SLOTS);

endpackage

// File: rtl/tdm_demux8_slot_decoder.sv
// Combinational SEL_W-to-LANES one-hot decoder with enable; drives the
// per-lane collect write enables and the lane_en strobe.
module slot_decoder #(
    parameter int SEL_W = 3,
    parameter int LANES = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [LANES-1:0] onehot
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign onehot[i] = en && (sel == SEL_W'(i));
    end

endmodule

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: serial bits are spread over 8 lanes and each
// completed frame is offered on a valid/ready port. Optional: TDM_DEMUX_PARITY_EN.
module tdm_demux8
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [LANES-1:0] lane_out,
    output logic [LANES-1:0] lane_en,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             sync_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);
    localparam logic [SLOT_W-1:0] LAST_DATA = SLOT_W'(LANES - 1);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] wr_slot;
    logic [LANES-1:0]  collect;
    logic [LANES-1:0]  collect_nxt;
    logic [LANES-1:0]  dec;
    logic              accept;
    logic              restart;
    logic              is_data;
    logic              complete;
    logic              load;

    // A sync always forces the current bit into slot 0, whatever the counter says.
    always_comb begin
        accept   = din_valid && (state == COLLECT || sync);
        restart  = din_valid && sync && (state == COLLECT) && (slot != '0);
        wr_slot  = sync ? '0 : slot;
        is_data  = accept && (wr_slot <= LAST_DATA);
        complete = accept && (wr_slot == LAST_SLOT);
        load     = complete && (!frame_valid || frame_ready);
    end

    slot_decoder #(
        .SEL_W (SEL_W),
        .LANES (LANES)
    ) u_dec (
        .sel    (wr_slot[SEL_W-1:0]),
        .en     (is_data),
        .onehot (dec)
    );

    always_comb begin
        collect_nxt = ((restart ? '0 : collect) & ~dec) | (dec & {LANES{din}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= '0;
            collect     <= '0;
            lane_out    <= '0;
            lane_en     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            lane_en  <= dec;
            sync_err <= restart;
            if (accept) begin
                state <= COLLECT;
                slot  <= complete ? '0 : wr_slot + 1'b1;
            end
            collect <= complete ? '0 : collect_nxt;
            if (load) begin
                lane_out    <= collect_nxt;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            // A frame that finds the output still occupied is lost.
            if (complete && !load)
                overrun <= 1'b1;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Completion happens on the parity slot, so din is the parity bit here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else
            parity_err <= load && ((^collect) ^ din);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed scenarios plus randomized traffic checked
// against a frame-level reference model.
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FS = 9;
`else
    localparam int FS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0, din_valid = 1'b0, sync = 1'b0, frame_ready = 1'b0;
    logic [7:0] lane_out, lane_en;
    logic       frame_valid, sync_err, overrun, parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit       m_in_frame;
    int       m_pos;
    bit [7:0] m_acc, m_data;
    bit       m_valid, m_over;
    bit [7:0] e_lane_en;
    bit       e_sync_err, e_par;

    tdm_demux8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .lane_out    (lane_out),
        .lane_en     (lane_en),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_in_frame = 0; m_pos = 0; m_acc = 0; m_data = 0;
        m_valid = 0; m_over = 0; e_lane_en = 0; e_sync_err = 0; e_par = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at edge+1.
    task automatic step(input logic d, input logic v, input logic s, input logic r);
        bit old_valid;
        @(negedge clk);
        din = d; din_valid = v; sync = s; frame_ready = r;
        @(posedge clk);
        old_valid = m_valid;
        e_lane_en = 0; e_sync_err = 0; e_par = 0;
        if (old_valid && r) m_valid = 0;
        if (v && (m_in_frame || s)) begin
            if (s) begin
                if (m_in_frame && m_pos != 0) e_sync_err = 1;
                m_acc = 0;
                m_pos = 0;
            end
            m_in_frame = 1;
            if (m_pos < 8) begin
                m_acc[m_pos] = d;
                e_lane_en[m_pos] = 1;
            end
            m_pos++;
            if (m_pos == FS) begin
                if (old_valid && !r) m_over = 1;
                else begin
                    m_data = m_acc;
                    m_valid = 1;
                    if (FS == 9) e_par = (^m_acc) ^ d;
                end
                m_pos = 0;
                m_acc = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; din = 0; din_valid = 0; sync = 0; frame_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        n_cmp++; if (lane_out !== 8'h00) begin n_bad++; $display("FAIL reset_lane_out: got %h want 00", lane_out); end
        n_cmp++; if (lane_en !== 8'h00) begin n_bad++; $display("FAIL reset_lane_en: got %h want 00", lane_en); end
        n_cmp++; if ({frame_valid, sync_err, overrun, parity_err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {frame_valid, sync_err, overrun, parity_err});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_frame_a5();
        logic [7:0] d = 8'hA5;
        logic [7:0] want_en;
        for (int i = 0; i < FS; i++) begin
            step((i < 8) ? d[i] : ^d, 1'b1, i == 0, 1'b1);
            want_en = (i < 8) ? 8'(1 << i) : 8'h00;
            n_cmp++; if (lane_en !== want_en) begin n_bad++; $display("FAIL a5_lane_en[%0d]: got %h want %h", i, lane_en, want_en); end
            n_cmp++; if (frame_valid !== (i == FS - 1)) begin n_bad++; $display("FAIL a5_valid[%0d]: got %b want %b", i, frame_valid, i == FS - 1); end
        end
        n_cmp++; if (lane_out !== 8'hA5) begin n_bad++; $display("FAIL a5_lane_out: got %h want a5", lane_out); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL a5_valid_drop: got %b want 0", frame_valid); end
        n_cmp++; if (lane_en !== 8'h00) begin n_bad++; $display("FAIL a5_idle_en: got %h want 00", lane_en); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fr [2];
        int f, k;
        fr[0] = 8'h3C; fr[1] = 8'hC3;
        do_reset();
        for (int i = 0; i < 2 * FS; i++) begin
            f = i / FS; k = i % FS;
            step((k < 8) ? fr[f][k] : ^fr[f], 1'b1, i == 0, 1'b1);
            n_cmp++; if (frame_valid !== (k == FS - 1)) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, frame_valid, k == FS - 1); end
            if (k == FS - 1) begin
                n_cmp++; if (lane_out !== fr[f]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", f, lane_out, fr[f]); end
            end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_mid_sync();
        logic [3:0] pre_d = 4'b1101;
        logic [3:0] pre_s = 4'b1001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(pre_d[i], 1'b1, pre_s[i], 1'b1);
            n_cmp++; if (sync_err !== (i == 3)) begin n_bad++; $display("FAIL msync_err[%0d]: got %b want %b", i, sync_err, i == 3); end
        end
        for (int i = 1; i < FS; i++) begin
            step((i < 8) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
            n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL msync_err_tail[%0d]: got %b want 0", i, sync_err); end
        end
        n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL msync_valid: got %b want 1", frame_valid); end
        n_cmp++; if (lane_out !== 8'h01) begin n_bad++; $display("FAIL msync_data: got %h want 01", lane_out); end
    endtask

    task automatic test_overrun();
        logic [7:0] fr [2];
        fr[0] = 8'h11; fr[1] = 8'h22;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FS; k++)
                step((k < 8) ? fr[f][k] : ^fr[f], 1'b1, f == 0 && k == 0, 1'b0);
            n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid[%0d]: got %b want 1", f, frame_valid); end
            n_cmp++; if (lane_out !== 8'h11) begin n_bad++; $display("FAIL ovr_data[%0d]: got %h want 11", f, lane_out); end
            n_cmp++; if (overrun !== (f == 1)) begin n_bad++; $display("FAIL ovr_flag[%0d]: got %b want %b", f, overrun, f == 1); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consume: got %b want 0", frame_valid); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (lane_en !== 8'h00) begin n_bad++; $display("FAIL rmid_lane_en: got %h want 00", lane_en); end
        n_cmp++; if ({lane_out, frame_valid, sync_err, overrun, parity_err} !== 12'h000) begin
            n_bad++; $display("FAIL rmid_outs: got %h want 000", {lane_out, frame_valid, sync_err, overrun, parity_err});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            n_cmp++; if (lane_en !== 8'h00) begin n_bad++; $display("FAIL rmid_ignored[%0d]: got %h want 00", i, lane_en); end
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d = 8'hA5;
        logic [1:0] pbit = 2'b10;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FS; k++)
                step((k < 8) ? d[k] : pbit[f], 1'b1, f == 0 && k == 0, 1'b1);
            n_cmp++; if (parity_err !== (f == 1)) begin n_bad++; $display("FAIL par_err[%0d]: got %b want %b", f, parity_err, f == 1); end
            n_cmp++; if (frame_valid !== 1'b1 || lane_out !== 8'hA5) begin
                n_bad++; $display("FAIL par_frame[%0d]: got %b/%h want 1/a5", f, frame_valid, lane_out);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic d, v, s, r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            d = 1'($urandom);
            v = ($urandom_range(3) != 0);
            s = ($urandom_range(15) == 0);
            r = 1'($urandom);
            step(d, v, s, r);
            n_cmp++; if (lane_out !== m_data) begin n_bad++; $display("FAIL rnd_lane_out@%0d: got %h want %h", c, lane_out, m_data); end
            n_cmp++; if (lane_en !== e_lane_en) begin n_bad++; $display("FAIL rnd_lane_en@%0d: got %h want %h", c, lane_en, e_lane_en); end
            n_cmp++; if (frame_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, frame_valid, m_valid); end
            n_cmp++; if (sync_err !== e_sync_err) begin n_bad++; $display("FAIL rnd_sync_err@%0d: got %b want %b", c, sync_err, e_sync_err); end
            n_cmp++; if (overrun !== m_over) begin n_bad++; $display("FAIL rnd_overrun@%0d: got %b want %b", c, overrun, m_over); end
            n_cmp++; if (parity_err !== e_par) begin n_bad++; $display("FAIL rnd_parity@%0d: got %b want %b", c, parity_err, e_par); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_mid_sync();
        test_overrun();
        test_reset_mid();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
